// File: rtl/rom_dl_writer.sv
// rom_dl_writer: turns the ioctl byte stream into SDRAM toggle-handshake writes and palette strobes,
// and raises rom_loaded / releases core_reset once a download has fully drained.
module rom_dl_writer #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [24:0] PAL_BASE   = 25'h18000,
   parameter int          PAL_SIZE   = 32,
   parameter int          TIMEOUT    = 255
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        status_reset,
   output logic        sdram_req,
   input  logic        sdram_ack,
   output logic [22:0] sdram_a,
   output logic [1:0]  sdram_ds,
   output logic [15:0] sdram_d,
   output logic        sdram_we,
   output logic        pal_wr,
   output logic [4:0]  pal_addr,
   output logic [7:0]  pal_dat,
   output logic        rom_loaded,
   output logic        core_reset,
   output logic        overflow,
   output logic        ack_timeout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL    = FIFO_DEPTH[AW:0];
   localparam logic [TW-1:0] TMAX    = TIMEOUT[TW-1:0];
   localparam logic [25:0]   PAL_END = {1'b0, PAL_BASE} + PAL_SIZE[25:0];
   typedef enum logic {IDLE, WAIT_ACK} state_t;
   state_t state;
   logic wr_q, seen, ev, is_pal, full, empty, push, pop;
   logic [31:0] mem [FIFO_DEPTH];
   logic [31:0] head;
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic [TW-1:0] tcnt;
   assign ev     = ioctl_wr & ~wr_q & ioctl_download;
   assign is_pal = (ioctl_addr >= PAL_BASE) && ({1'b0, ioctl_addr} < PAL_END);
   assign full   = cnt == FULL;
   assign empty  = cnt == '0;
   assign push   = ev & ~is_pal & ~full;
   assign pop    = (state == IDLE) & ~empty;
   assign head   = mem[rp];
   // Entries keep addr[23:0] only: addr[24] matters solely for the palette compare.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wp] <= {ioctl_addr[23:0], ioctl_dout};
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_q        <= 1'b0;
         seen        <= 1'b0;
         wp          <= '0;
         rp          <= '0;
         cnt         <= '0;
         tcnt        <= '0;
         sdram_req   <= 1'b0;
         sdram_we    <= 1'b0;
         sdram_a     <= '0;
         sdram_ds    <= '0;
         sdram_d     <= '0;
         pal_wr      <= 1'b0;
         pal_addr    <= '0;
         pal_dat     <= '0;
         rom_loaded  <= 1'b0;
         core_reset  <= 1'b1;
         overflow    <= 1'b0;
         ack_timeout <= 1'b0;
      end else begin
         wr_q   <= ioctl_wr;
         pal_wr <= ev & is_pal;
         if (ev & is_pal) begin
            pal_addr <= ioctl_addr[4:0];
            pal_dat  <= ioctl_dout;
         end
         if (ev & ~is_pal & full) overflow <= 1'b1;
         if (ioctl_download) seen <= 1'b1;
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (state == IDLE) begin
            if (!empty) begin
               sdram_a   <= head[31:9];
               sdram_ds  <= {head[8], ~head[8]};
               sdram_d   <= {2{head[7:0]}};
               sdram_we  <= 1'b1;
               sdram_req <= ~sdram_req;
               tcnt      <= '0;
               state     <= WAIT_ACK;
            end
         end else if (sdram_ack == sdram_req) begin
            sdram_we <= 1'b0;
            state    <= IDLE;
         end else if (tcnt == TMAX) begin
            // Give up on this entry without re-toggling; the next issue toggles again.
            ack_timeout <= 1'b1;
            sdram_we    <= 1'b0;
            state       <= IDLE;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
         if (!ioctl_download && seen && empty && state == IDLE) rom_loaded <= 1'b1;
         core_reset <= status_reset | ioctl_download | ~rom_loaded;
      end
   end
endmodule

// File: tb/tb_rom_dl_writer.sv
// tb_rom_dl_writer: directed vector table for routing/capture, plus overflow, timeout,
// drain and asynchronous-reset sequences against a toggle-echo SDRAM model.
module tb_rom_dl_writer;
   logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, status_reset = 1'b0;
   logic hold = 1'b0, sdram_ack;
   logic [24:0] ioctl_addr = '0;
   logic [7:0] ioctl_dout = '0;
   logic sdram_req, sdram_we, pal_wr, rom_loaded, core_reset, overflow, ack_timeout;
   logic [22:0] sdram_a;
   logic [1:0] sdram_ds;
   logic [15:0] sdram_d;
   logic [4:0] pal_addr;
   logic [7:0] pal_dat;
   int applied = 0, miscompares = 0, toggles = 0, acks = 0;
   logic last_req = 1'b0, last_ack = 1'b0;
   typedef struct {
      logic        dl;
      logic [24:0] addr;
      logic [7:0]  dat;
      logic        pal;
      logic        sd;
      logic [22:0] a;
      logic [1:0]  ds;
   } vec_t;
   vec_t vt [10];
   always #5 clk_sys = ~clk_sys;
   rom_dl_writer dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .status_reset(status_reset),
      .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_a(sdram_a), .sdram_ds(sdram_ds),
      .sdram_d(sdram_d), .sdram_we(sdram_we), .pal_wr(pal_wr), .pal_addr(pal_addr),
      .pal_dat(pal_dat), .rom_loaded(rom_loaded), .core_reset(core_reset),
      .overflow(overflow), .ack_timeout(ack_timeout)
   );
   // SDRAM model: echoes req one edge later unless held.
   always @(posedge clk_sys or posedge reset) begin
      if (reset) sdram_ack <= 1'b0;
      else if (!hold) sdram_ack <= sdram_req;
   end
   always @(negedge clk_sys) begin
      if (sdram_req !== last_req) toggles <= toggles + 1;
      if (sdram_ack !== last_ack) acks <= acks + 1;
      last_req <= sdram_req;
      last_ack <= sdram_ack;
   end
   task automatic tick;
      @(negedge clk_sys);
      #1;
   endtask
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic check_reset_vals(input string name);
      check(name, {sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d, pal_wr, pal_addr, pal_dat,
                   rom_loaded, core_reset, overflow, ack_timeout}, 64'd4);
   endtask
   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      tick;
   endtask
   task automatic send(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr = 1'b1;
      tick;
      ioctl_wr = 1'b0;
      tick;
   endtask
   initial begin
      int t0, a0, n, wc, pc, ok;
      logic [4:0] pa;
      logic [7:0] pd;
      vt[0] = '{1'b1, 25'h0000003, 8'hA5, 1'b0, 1'b1, 23'h000001, 2'b10};
      vt[1] = '{1'b1, 25'h0018007, 8'h3C, 1'b1, 1'b0, 23'h0,      2'b00};
      vt[2] = '{1'b1, 25'h0018020, 8'h5A, 1'b0, 1'b1, 23'h00C010, 2'b01};
      vt[3] = '{1'b1, 25'h0017FFF, 8'h11, 1'b0, 1'b1, 23'h00BFFF, 2'b10};
      vt[4] = '{1'b1, 25'h0018000, 8'h22, 1'b1, 1'b0, 23'h0,      2'b00};
      vt[5] = '{1'b1, 25'h001801F, 8'h33, 1'b1, 1'b0, 23'h0,      2'b00};
      vt[6] = '{1'b1, 25'h1018000, 8'h44, 1'b0, 1'b1, 23'h00C000, 2'b01};
      vt[7] = '{1'b1, 25'h1FFFFFF, 8'h55, 1'b0, 1'b1, 23'h7FFFFF, 2'b10};
      vt[8] = '{1'b0, 25'h0000010, 8'h66, 1'b0, 1'b0, 23'h0,      2'b00};
      vt[9] = '{1'b0, 25'h0018001, 8'h77, 1'b0, 1'b0, 23'h0,      2'b00};
      tick;
      check_reset_vals("reset_state");
      reset = 1'b0;
      tick;
      for (int i = 0; i < 10; i++) begin
         ioctl_download = vt[i].dl;
         t0 = toggles;
         wc = 0;
         pc = 0;
         pa = '0;
         pd = '0;
         ioctl_addr = vt[i].addr;
         ioctl_dout = vt[i].dat;
         ioctl_wr = 1'b1;
         for (int k = 0; k < 8; k++) begin
            tick;
            ioctl_wr = 1'b0;
            if (sdram_we) wc++;
            if (pal_wr) begin
               pc++;
               pa = pal_addr;
               pd = pal_dat;
            end
         end
         check($sformatf("v%0d_toggles", i), toggles - t0, vt[i].sd);
         check($sformatf("v%0d_pal_strobes", i), pc, vt[i].pal);
         check($sformatf("v%0d_we_cycles", i), wc, vt[i].sd ? 2 : 0);
         if (vt[i].sd) begin
            check($sformatf("v%0d_sdram_a", i), sdram_a, vt[i].a);
            check($sformatf("v%0d_sdram_ds", i), sdram_ds, vt[i].ds);
            check($sformatf("v%0d_sdram_d", i), sdram_d, {vt[i].dat, vt[i].dat});
         end
         if (vt[i].pal) begin
            check($sformatf("v%0d_pal_addr", i), pa, vt[i].addr[4:0]);
            check($sformatf("v%0d_pal_dat", i), pd, vt[i].dat);
         end
      end
      // Overflow: ack withheld, six events, the sixth is dropped.
      do_reset;
      ioctl_download = 1'b1;
      hold = 1'b1;
      t0 = toggles;
      for (int k = 1; k <= 6; k++) send(25'(k * 256), 8'(k));
      check("ovf_flag", overflow, 1);
      check("ovf_inflight_toggles", toggles - t0, 1);
      check("ovf_no_timeout", ack_timeout, 0);
      hold = 1'b0;
      repeat (30) tick;
      check("ovf_total_toggles", toggles - t0, 5);
      check("ovf_last_a", sdram_a, 23'h280);
      check("ovf_we_idle", sdram_we, 0);
      check("ovf_sticky", overflow, 1);
      // Timeout: ack never returns.
      do_reset;
      ioctl_download = 1'b1;
      hold = 1'b1;
      t0 = toggles;
      send(25'h40, 8'h01);
      check("to_issue_we", sdram_we, 1);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         tick;
         n++;
         if (n == 1) begin
            ioctl_addr = 25'h80;
            ioctl_dout = 8'h02;
            ioctl_wr = 1'b1;
         end else ioctl_wr = 1'b0;
         if (ack_timeout) break;
      end
      check("to_cycles", n, 256);
      check("to_we_forced_low", sdram_we, 0);
      tick;
      check("to_next_a", sdram_a, 23'h40);
      check("to_next_we", sdram_we, 1);
      check("to_toggles", toggles - t0, 2);
      check("to_sticky", ack_timeout, 1);
      // Drain: download falls with three entries outstanding.
      do_reset;
      hold = 1'b0;
      tick;
      ioctl_download = 1'b1;
      hold = 1'b1;
      send(25'h2000, 8'h10);
      send(25'h2002, 8'h20);
      send(25'h2004, 8'h30);
      ioctl_download = 1'b0;
      tick;
      tick;
      check("drain_not_loaded", rom_loaded, 0);
      a0 = acks;
      hold = 1'b0;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         tick;
         if (rom_loaded) begin
            ok = 1;
            break;
         end
      end
      check("drain_loaded", ok, 1);
      check("drain_acks_at_load", acks - a0, 3);
      check("drain_core_reset_hold", core_reset, 1);
      tick;
      check("drain_core_reset_release", core_reset, 0);
      status_reset = 1'b1;
      tick;
      check("status_core_reset", core_reset, 1);
      check("status_rom_loaded", rom_loaded, 1);
      status_reset = 1'b0;
      // Async reset mid WAIT_ACK with entries queued.
      do_reset;
      ioctl_download = 1'b1;
      hold = 1'b1;
      send(25'h3000, 8'hA1);
      send(25'h3002, 8'hA2);
      send(25'h3004, 8'hA3);
      check("ar_pre_we", sdram_we, 1);
      #2 reset = 1'b1;
      #1 check_reset_vals("ar_immediate");
      tick;
      ioctl_download = 1'b0;
      hold = 1'b0;
      reset = 1'b0;
      tick;
      tick;
      t0 = toggles;
      repeat (10) tick;
      check("ar_no_toggle", toggles - t0, 0);
      check("ar_we", sdram_we, 0);
      check("ar_req", sdram_req, 0);
      check("ar_rom_loaded", rom_loaded, 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
